// File: rtl/alu_status_unit_pkg.sv
// Shared definitions for the ALU / status-register stage: P bit positions,
// the reset value of P, the ALU operation encoding and the op-strobe decoder.
package alu_status_unit_pkg;

    // Bit positions inside P = {N,V,1,B,D,I,Z,C}
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    // Bit5 set, I set, everything else clear
    localparam logic [7:0] P_RESET_DEFAULT = 8'h24;

    // Resolved ALU operation after strobe prioritisation
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_SUM  = 3'd1,
        OP_SR   = 3'd2,
        OP_AND  = 3'd3,
        OP_EOR  = 3'd4,
        OP_OR   = 3'd5
    } alu_op_e;

    // Several strobes may be asserted at once; SUMS > SRS > ANDS > EORS > ORS
    function automatic alu_op_e decode_op(
        input logic sums,
        input logic srs,
        input logic ands,
        input logic eors,
        input logic ors
    );
        alu_op_e op;
        op = OP_NONE;
        if (sums) begin
            op = OP_SUM;
        end else if (srs) begin
            op = OP_SR;
        end else if (ands) begin
            op = OP_AND;
        end else if (eors) begin
            op = OP_EOR;
        end else if (ors) begin
            op = OP_OR;
        end
        return op;
    endfunction

endpackage

// File: rtl/alu_status_unit_bcd_adjust.sv
// NMOS-6502 style decimal adder: adds two packed-BCD bytes with carry-in and
// applies the +6 per-nibble correction. Only present when ALU_DECIMAL_EN is
// defined; the binary-only build has no use for it.
`ifdef ALU_DECIMAL_EN
module alu_bcd_adjust (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       carry
);

    logic [5:0] lo_raw;
    logic [5:0] lo_adj;
    logic       half_carry;
    logic [5:0] hi_raw;
    logic [5:0] hi_adj;

    // Low nibble first; its decimal carry feeds the high nibble
    always_comb begin
        lo_raw     = 6'(a[3:0]) + 6'(b[3:0]) + 6'(cin);
        half_carry = 1'b0;
        lo_adj     = lo_raw;
        if (lo_raw > 6'd9) begin
            lo_adj     = lo_raw + 6'd6;
            half_carry = 1'b1;
        end

        hi_raw = 6'(a[7:4]) + 6'(b[7:4]) + 6'(half_carry);
        carry  = 1'b0;
        hi_adj = hi_raw;
        if (hi_raw > 6'd9) begin
            hi_adj = hi_raw + 6'd6;
            carry  = 1'b1;
        end

        sum = {hi_adj[3:0], lo_adj[3:0]};
    end

endmodule
`endif

// File: rtl/alu_status_unit.sv
// 6502 ALU stage (AI/BI input latches, ADD hold register, registered carry and
// overflow) plus the processor status register P. Everything is clocked on
// clk_ph2 with a synchronous active-high reset.
// Optional feature macro: ALU_DECIMAL_EN -- when defined, SUMS honours the D
// flag with NMOS-6502 BCD correction; otherwise SUMS is always binary and D is
// only stored.
import alu_status_unit_pkg::*;

module alu_status_unit #(
    parameter logic [7:0] P_RESET = P_RESET_DEFAULT
) (
    input  logic       clk_ph2,
    input  logic       rst,
    input  logic [7:0] sb,
    input  logic [7:0] db,
    input  logic       ir5,
    input  logic       SB_ADD,
    input  logic       Z_ADD,
    input  logic       DB_ADD,
    input  logic       nDB_ADD,
    input  logic       nONE_ADD,
    input  logic       C_ONE,
    input  logic       SUMS,
    input  logic       ANDS,
    input  logic       EORS,
    input  logic       ORS,
    input  logic       SRS,
    input  logic       ACR_C,
    input  logic       AVR_V,
    input  logic       DBZ_Z,
    input  logic       DB7_N,
    input  logic       IR5_C,
    input  logic       IR5_I,
    input  logic       IR5_D,
    output logic [7:0] add,
    output logic       acr,
    output logic       avr,
    output logic [7:0] p
);

    logic [7:0] ai_q;
    logic [7:0] bi_q;
    logic [7:0] a_op;
    logic [7:0] b_op;
    logic [7:0] add_q;
    logic [7:0] add_d;
    logic       acr_q;
    logic       acr_d;
    logic       avr_q;
    logic       avr_d;
    logic [7:0] p_q;
    logic [7:0] p_d;
    logic       cin;
    logic [8:0] bin_sum;
    logic       bin_ovf;
    logic [7:0] sum_result;
    logic       sum_carry;
    alu_op_e    alu_op;

    // Operands seen by this cycle's op are what the latches will capture at
    // this edge, so a select and a strobe in the same cycle work together
    always_comb begin
        a_op = ai_q;
        if (Z_ADD) begin
            a_op = 8'h00;
        end else if (SB_ADD) begin
            a_op = sb;
        end

        b_op = bi_q;
        if (nONE_ADD) begin
            b_op = 8'hFF;
        end else if (nDB_ADD) begin
            b_op = ~db;
        end else if (DB_ADD) begin
            b_op = db;
        end
    end

    assign cin     = C_ONE | p_q[P_C];
    assign bin_sum = {1'b0, a_op} + {1'b0, b_op} + {8'h00, cin};
    assign bin_ovf = (a_op[7] == b_op[7]) & (bin_sum[7] != a_op[7]);
    assign alu_op  = decode_op(SUMS, SRS, ANDS, EORS, ORS);

`ifdef ALU_DECIMAL_EN
    logic [7:0] dec_sum;
    logic       dec_carry;

    alu_bcd_adjust u_bcd (
        .a     (a_op),
        .b     (b_op),
        .cin   (cin),
        .sum   (dec_sum),
        .carry (dec_carry)
    );

    // Decimal mode swaps in the corrected sum and decimal carry; overflow
    // still comes from the binary sum
    always_comb begin
        sum_result = bin_sum[7:0];
        sum_carry  = bin_sum[8];
        if (p_q[P_D]) begin
            sum_result = dec_sum;
            sum_carry  = dec_carry;
        end
    end
`else
    // Binary-only build: D flag has no effect on the adder
    always_comb begin
        sum_result = bin_sum[7:0];
        sum_carry  = bin_sum[8];
    end
`endif

    // Result selection; with no strobe the hold registers keep their value
    always_comb begin
        add_d = add_q;
        acr_d = acr_q;
        avr_d = avr_q;
        case (alu_op)
            OP_SUM: begin
                add_d = sum_result;
                acr_d = sum_carry;
                avr_d = bin_ovf;
            end
            OP_SR: begin
                add_d = {cin, a_op[7:1]};
                acr_d = a_op[0];
                avr_d = 1'b0;
            end
            OP_AND: begin
                add_d = a_op & b_op;
                acr_d = 1'b0;
                avr_d = 1'b0;
            end
            OP_EOR: begin
                add_d = a_op ^ b_op;
                acr_d = 1'b0;
                avr_d = 1'b0;
            end
            OP_OR: begin
                add_d = a_op | b_op;
                acr_d = 1'b0;
                avr_d = 1'b0;
            end
            default: begin
                add_d = add_q;
                acr_d = acr_q;
                avr_d = avr_q;
            end
        endcase
    end

    // Flag loads read the registered acr/avr, i.e. the previous op's result,
    // even when an op strobe lands in the same cycle
    always_comb begin
        p_d = p_q;
        if (IR5_C) begin
            p_d[P_C] = ir5;
        end else if (ACR_C) begin
            p_d[P_C] = acr_q;
        end
        if (DBZ_Z) begin
            p_d[P_Z] = (db == 8'h00);
        end
        if (IR5_I) begin
            p_d[P_I] = ir5;
        end
        if (IR5_D) begin
            p_d[P_D] = ir5;
        end
        if (AVR_V) begin
            p_d[P_V] = avr_q;
        end
        if (DB7_N) begin
            p_d[P_N] = db[7];
        end
        p_d[P_B] = P_RESET[P_B];
        p_d[P_U] = 1'b1;
    end

    // State registers; reset drops any op strobed in the same cycle
    always_ff @(posedge clk_ph2) begin
        if (rst) begin
            ai_q  <= 8'h00;
            bi_q  <= 8'h00;
            add_q <= 8'h00;
            acr_q <= 1'b0;
            avr_q <= 1'b0;
            p_q   <= P_RESET | 8'h20;
        end else begin
            ai_q  <= a_op;
            bi_q  <= b_op;
            add_q <= add_d;
            acr_q <= acr_d;
            avr_q <= avr_d;
            p_q   <= p_d;
        end
    end

    assign add = add_q;
    assign acr = acr_q;
    assign avr = avr_q;
    assign p   = p_q;

endmodule

// File: tb/tb_alu_status_unit.sv
// Directed, table-driven bench for alu_status_unit. Expected values are hand
// computed; decimal-mode rows switch on ALU_DECIMAL_EN.
module tb_alu_status_unit;

    localparam logic [17:0] M_SB_ADD   = 18'h00001;
    localparam logic [17:0] M_Z_ADD    = 18'h00002;
    localparam logic [17:0] M_DB_ADD   = 18'h00004;
    localparam logic [17:0] M_NDB_ADD  = 18'h00008;
    localparam logic [17:0] M_NONE_ADD = 18'h00010;
    localparam logic [17:0] M_C_ONE    = 18'h00020;
    localparam logic [17:0] M_SUMS     = 18'h00040;
    localparam logic [17:0] M_ANDS     = 18'h00080;
    localparam logic [17:0] M_EORS     = 18'h00100;
    localparam logic [17:0] M_ORS      = 18'h00200;
    localparam logic [17:0] M_SRS      = 18'h00400;
    localparam logic [17:0] M_ACR_C    = 18'h00800;
    localparam logic [17:0] M_AVR_V    = 18'h01000;
    localparam logic [17:0] M_DBZ_Z    = 18'h02000;
    localparam logic [17:0] M_DB7_N    = 18'h04000;
    localparam logic [17:0] M_IR5_C    = 18'h08000;
    localparam logic [17:0] M_IR5_I    = 18'h10000;
    localparam logic [17:0] M_IR5_D    = 18'h20000;

    typedef struct {
        string       name;
        logic [7:0]  sb_v;
        logic [7:0]  db_v;
        logic        ir5_v;
        logic [17:0] ctl;
        logic [7:0]  exp_add;
        logic        exp_acr;
        logic        exp_avr;
        logic [7:0]  exp_p;
    } vec_t;

    logic       clk_ph2 = 1'b0;
    logic       rst;
    logic [7:0] sb;
    logic [7:0] db;
    logic       ir5;
    logic       SB_ADD, Z_ADD, DB_ADD, nDB_ADD, nONE_ADD, C_ONE;
    logic       SUMS, ANDS, EORS, ORS, SRS;
    logic       ACR_C, AVR_V, DBZ_Z, DB7_N, IR5_C, IR5_I, IR5_D;
    logic [7:0] add;
    logic       acr;
    logic       avr;
    logic [7:0] p;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    alu_status_unit dut (
        .clk_ph2  (clk_ph2),
        .rst      (rst),
        .sb       (sb),
        .db       (db),
        .ir5      (ir5),
        .SB_ADD   (SB_ADD),
        .Z_ADD    (Z_ADD),
        .DB_ADD   (DB_ADD),
        .nDB_ADD  (nDB_ADD),
        .nONE_ADD (nONE_ADD),
        .C_ONE    (C_ONE),
        .SUMS     (SUMS),
        .ANDS     (ANDS),
        .EORS     (EORS),
        .ORS      (ORS),
        .SRS      (SRS),
        .ACR_C    (ACR_C),
        .AVR_V    (AVR_V),
        .DBZ_Z    (DBZ_Z),
        .DB7_N    (DB7_N),
        .IR5_C    (IR5_C),
        .IR5_I    (IR5_I),
        .IR5_D    (IR5_D),
        .add      (add),
        .acr      (acr),
        .avr      (avr),
        .p        (p)
    );

    // Free-running phase-2 clock
    always #5 clk_ph2 = ~clk_ph2;

    // Drive one cycle's inputs just after the falling edge
    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d,
                                 input logic i5, input logic [17:0] c);
        @(negedge clk_ph2);
        sb       = s;
        db       = d;
        ir5      = i5;
        SB_ADD   = c[0];
        Z_ADD    = c[1];
        DB_ADD   = c[2];
        nDB_ADD  = c[3];
        nONE_ADD = c[4];
        C_ONE    = c[5];
        SUMS     = c[6];
        ANDS     = c[7];
        EORS     = c[8];
        ORS      = c[9];
        SRS      = c[10];
        ACR_C    = c[11];
        AVR_V    = c[12];
        DBZ_Z    = c[13];
        DB7_N    = c[14];
        IR5_C    = c[15];
        IR5_I    = c[16];
        IR5_D    = c[17];
    endtask

    // Sample just after the rising edge and compare all four outputs
    task automatic checkOutput(input string name, input logic [7:0] e_add,
                               input logic e_acr, input logic e_avr,
                               input logic [7:0] e_p);
        @(posedge clk_ph2);
        #1;
        total++;
        if (add !== e_add) begin
            bad++;
            $display("[TB] FAIL %s add: got %02h want %02h", name, add, e_add);
        end
        total++;
        if (acr !== e_acr) begin
            bad++;
            $display("[TB] FAIL %s acr: got %0b want %0b", name, acr, e_acr);
        end
        total++;
        if (avr !== e_avr) begin
            bad++;
            $display("[TB] FAIL %s avr: got %0b want %0b", name, avr, e_avr);
        end
        total++;
        if (p !== e_p) begin
            bad++;
            $display("[TB] FAIL %s p: got %02h want %02h", name, p, e_p);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [7:0] s,
                                input logic [7:0] d, input logic i5,
                                input logic [17:0] c, input logic [7:0] ea,
                                input logic ec, input logic ev,
                                input logic [7:0] ep);
        vec_t v;
        v.name = n; v.sb_v = s; v.db_v = d; v.ir5_v = i5; v.ctl = c;
        v.exp_add = ea; v.exp_acr = ec; v.exp_avr = ev; v.exp_p = ep;
        return v;
    endfunction

    // Main sequence: table rows carry state forward from one row to the next
    initial begin
        vecs.push_back(mk("idle", 8'h00, 8'h00, 1'b0, 18'h0, 8'h00, 1'b0, 1'b0, 8'h24));
        vecs.push_back(mk("add7F01", 8'h7F, 8'h01, 1'b0, M_SB_ADD | M_DB_ADD | M_SUMS,
                          8'h80, 1'b0, 1'b1, 8'h24));
        vecs.push_back(mk("loadVC", 8'h00, 8'h00, 1'b0, M_AVR_V | M_ACR_C,
                          8'h80, 1'b0, 1'b1, 8'h64));
        vecs.push_back(mk("ir5CbeatsACR", 8'h00, 8'h00, 1'b1, M_IR5_C | M_ACR_C,
                          8'h80, 1'b0, 1'b1, 8'h65));
        vecs.push_back(mk("sbcC1", 8'h05, 8'h03, 1'b0, M_SB_ADD | M_NDB_ADD | M_SUMS,
                          8'h02, 1'b1, 1'b0, 8'h65));
        vecs.push_back(mk("clc", 8'h00, 8'h00, 1'b0, M_IR5_C,
                          8'h02, 1'b1, 1'b0, 8'h64));
        vecs.push_back(mk("sbcC0", 8'h05, 8'h03, 1'b0, M_SB_ADD | M_NDB_ADD | M_SUMS,
                          8'h01, 1'b1, 1'b0, 8'h64));
        vecs.push_back(mk("inxWrap", 8'hFF, 8'h00, 1'b0,
                          M_SB_ADD | M_DB_ADD | M_C_ONE | M_SUMS, 8'h00, 1'b1, 1'b0, 8'h64));
        vecs.push_back(mk("zeroNZC", 8'h00, 8'h00, 1'b0, M_DBZ_Z | M_DB7_N | M_ACR_C,
                          8'h00, 1'b1, 1'b0, 8'h67));
        vecs.push_back(mk("flagOldAcr", 8'h7F, 8'h01, 1'b0,
                          M_SB_ADD | M_DB_ADD | M_SUMS | M_ACR_C | M_AVR_V,
                          8'h81, 1'b0, 1'b1, 8'h27));
        vecs.push_back(mk("negN", 8'h00, 8'h80, 1'b0, M_DBZ_Z | M_DB7_N,
                          8'h81, 1'b0, 1'b1, 8'hA5));
        vecs.push_back(mk("andHeld", 8'h00, 8'h00, 1'b0, M_ANDS,
                          8'h01, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk("orZeroFF", 8'h00, 8'h00, 1'b0, M_Z_ADD | M_NONE_ADD | M_ORS,
                          8'hFF, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk("eorHeldB", 8'h0F, 8'h00, 1'b0, M_SB_ADD | M_EORS,
                          8'hF0, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk("srsPrio", 8'hAB, 8'h12, 1'b0,
                          M_SB_ADD | M_DB_ADD | M_NDB_ADD | M_SRS | M_ANDS | M_ORS,
                          8'hD5, 1'b1, 1'b0, 8'hA5));
        vecs.push_back(mk("sumsPrio", 8'h55, 8'h00, 1'b0,
                          M_Z_ADD | M_SB_ADD | M_SUMS | M_SRS | M_ANDS,
                          8'hEE, 1'b0, 1'b0, 8'hA5));
        vecs.push_back(mk("cli", 8'h00, 8'h00, 1'b0, M_IR5_I,
                          8'hEE, 1'b0, 1'b0, 8'hA1));
        vecs.push_back(mk("seiSed", 8'h00, 8'h00, 1'b1, M_IR5_I | M_IR5_D,
                          8'hEE, 1'b0, 1'b0, 8'hAD));
        vecs.push_back(mk("clcDec", 8'h00, 8'h00, 1'b0, M_IR5_C,
                          8'hEE, 1'b0, 1'b0, 8'hAC));
`ifdef ALU_DECIMAL_EN
        vecs.push_back(mk("dec1928", 8'h19, 8'h28, 1'b0, M_SB_ADD | M_DB_ADD | M_SUMS,
                          8'h47, 1'b0, 1'b0, 8'hAC));
        vecs.push_back(mk("dec9901", 8'h99, 8'h01, 1'b0, M_SB_ADD | M_DB_ADD | M_SUMS,
                          8'h00, 1'b1, 1'b0, 8'hAC));
`else
        vecs.push_back(mk("bin1928", 8'h19, 8'h28, 1'b0, M_SB_ADD | M_DB_ADD | M_SUMS,
                          8'h41, 1'b0, 1'b0, 8'hAC));
        vecs.push_back(mk("bin9901", 8'h99, 8'h01, 1'b0, M_SB_ADD | M_DB_ADD | M_SUMS,
                          8'h9A, 1'b0, 1'b0, 8'hAC));
`endif

        // Reset and reset-state check
        rst = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0, 18'h0);
        checkOutput("reset", 8'h00, 1'b0, 1'b0, 8'h24);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sb_v, vecs[i].db_v, vecs[i].ir5_v, vecs[i].ctl);
            checkOutput(vecs[i].name, vecs[i].exp_add, vecs[i].exp_acr,
                        vecs[i].exp_avr, vecs[i].exp_p);
        end

        // Ten idle cycles: results and flags must hold
        for (int k = 0; k < 10; k++) begin
            applyStimulus(8'h5A, 8'hA5, 1'b1, 18'h0);
`ifdef ALU_DECIMAL_EN
            checkOutput("idleHold", 8'h00, 1'b1, 1'b0, 8'hAC);
`else
            checkOutput("idleHold", 8'h9A, 1'b0, 1'b0, 8'hAC);
`endif
        end

        // Reset asserted alongside a SUMS: op is discarded
        rst = 1'b1;
        applyStimulus(8'h7F, 8'h01, 1'b1,
                      M_SB_ADD | M_DB_ADD | M_SUMS | M_IR5_C | M_AVR_V);
        checkOutput("resetMidOp", 8'h00, 1'b0, 1'b0, 8'h24);
        rst = 1'b0;

        // Latches were cleared by reset, so an unselected OR yields zero
        applyStimulus(8'hFF, 8'hFF, 1'b0, M_ORS);
        checkOutput("latchCleared", 8'h00, 1'b0, 1'b0, 8'h24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
